rename_recovery_controller: RTL
===============================

# rename_recovery_controller

Keeps the committed (retirement) register mapping and drives both the reclaim port and the flush-recovery sequence of the rename stage. On every retire it translates committed destinations into freed physical registers for the rename free list. On a pipeline flush it stalls the front end and rebuilds rename state: it clears the free list, rewrites the frontend RAT from the committed map, and refills the free list with every physical register not in the committed map.

## Interface
Parameters come from `processor_help`; the block has no local overrides. Let AW = $clog2(ARCHITECTURAL_REGISTER_COUNT) and PW = $clog2(PHYSICAL_REGISTER_FILE_SIZE).
- SUPER_SCALAR_WIDTH (W), package value: commit lanes per cycle.
- ARCHITECTURAL_REGISTER_COUNT (A), package value: committed-map depth.
- PHYSICAL_REGISTER_FILE_SIZE (P), package value: number of scan positions in the rebuild.

Ports:
- clk_in  in  1  clock. One clock domain; reset is synchronous and active-high.
- rst_in  in  1  synchronous active-high reset.
- commit_valid_in  in  [W] x 1  lane retires an instruction that writes a register.
- commit_arch_dest_in  in  [W] x AW  architectural destination.
- commit_phys_dest_in  in  [W] x PW  physical register allocated at rename.
- retire_valid_out  out  [W] x 1  freed-register valid; connects to rename `retire_valid_in`.
- retire_freed_register_out  out  [W] x PW  previous committed mapping, now free.
- flush_in  in  1  flush request pulse.
- busy_out  out  1  recovery in progress; decode/rename must stall.
- freelist_clear_out  out  1  pulse: rename sets head = tail = count = 0.
- rat_restore_valid_out  out  1  write the frontend RAT this cycle.
- rat_restore_index_out  out  AW  architectural index.
- rat_restore_value_out  out  PW  committed physical register.
- freelist_push_valid_out  out  1  push one free register at the tail.
- freelist_push_register_out  out  PW  register to push.
- recovery_done_out  out  1  one-cycle pulse at the end of recovery.

## Operation
- **State:** the block holds:
  - committed_rat[A] (PW each);
  - committed_used[P], a bit per physical register, set iff some committed_rat entry maps to it.
- **Reset:**
  - committed_rat[i] = i; committed_used bits 0..A-1 = 1, all others 0.
  - FSM in IDLE; every output is 0.
- **Commit (IDLE only):**
  - Lanes are processed in order 0..W-1.
  - Lane i frees the mapping of commit_arch_dest_in[i] as it stands after lanes below i have been applied. So when two lanes target the same architectural register, the higher lane frees the lower lane's physical register.
  - For each applied lane: clear the used bit of the freed register, set the used bit of the new register, and update committed_rat.
- **Commit during recovery:** commits while busy_out = 1 are a protocol violation. The bench asserts on them and the RTL ignores them.
- **FSM:**
  - IDLE -> CLEAR on flush_in. Commits arriving in the same cycle as the flush are applied first, because they are older than the flush.
  - CLEAR (1 cycle): freelist_clear_out = 1.
  - RESTORE (A cycles): index k = 0..A-1; rat_restore_valid_out = 1, index = k, value = committed_rat[k].
  - REBUILD (P cycles): scan p = 0..P-1. When committed_used[p] = 0, assert freelist_push_valid_out with register p.
  - DONE (1 cycle): recovery_done_out = 1. Next state is IDLE.
- **Counters:** a single scan counter of width $clog2(P) covers both RESTORE and REBUILD. Its terminal compares are against A-1 and P-1, so there is no wrap.
- **Invariant:** REBUILD pushes exactly P-A registers, which fills the free list to depth.
- **flush_in outside IDLE:** ignored.
- **Reset mid-recovery:** return to IDLE with the reset mapping and all outputs 0. Rename is reset in the same cycle.

## Timing
- **Retire path:** retire_valid_out and retire_freed_register_out are registered and appear 1 cycle after the commit. Lanes with commit_valid_in = 0 produce retire_valid_out = 0.
- **busy_out:** registered. It is high from the cycle after flush_in through DONE inclusive.
- **Flush cycle:** the upstream stall for the flush cycle itself comes from flush_in directly.
- **Recovery latency:** 1 + A + P + 1 cycles from flush acceptance to the return to IDLE (98 for A = 32, P = 64).
- **Restore/rebuild outputs:** registered, one action per cycle, never more than one restore or push in a cycle.
- **Output exclusivity:** freelist_clear_out, rat_restore_valid_out and freelist_push_valid_out are mutually exclusive in every cycle.

## Structure
- `processor_help` holds:
  - the three size parameters;
  - a `RecoveryState` enum (IDLE, CLEAR, RESTORE, REBUILD, DONE);
  - a `CommitLane` struct (valid, arch_dest, phys_dest).
- No sub-module. committed_rat and committed_used sit inline with the FSM.
- Rename needs a restore port and a clear/push port. This block owns the sequencing of both.

## Test plan
Bench configuration: W = 2, A = 32, P = 64.
- **Reset, then 2 idle cycles:** all outputs 0, busy_out = 0, restore/push valid = 0.
- **Single commit:** lane 0 arch 5 -> phys 40. One cycle later: retire_valid_out[0] = 1, freed = 5. The committed map then holds 5 -> 40.
- **Same-destination lanes:** lane 0 arch 3 -> 33 and lane 1 arch 3 -> 34 in one cycle. Required: freed[0] = 3, freed[1] = 33, and committed 3 -> 34.
- **Flush after one commit:** commit 7 -> 50, then flush.
  - Expect 1 clear pulse.
  - Then 32 restore writes, with index 7 carrying value 50.
  - Then 32 pushes: 7, then 32..49, then 51..63, in that order.
  - recovery_done_out fires at cycle 98 and busy_out drops in the following cycle.
- **Flush coincident with commit 9 -> 60:** the commit is applied first, then restore index 9 = 60 and register 60 is not pushed. A second flush_in during RESTORE has no effect.
- **rst_in asserted in REBUILD:** the next cycle is IDLE with all outputs 0; a fresh flush restores the identity map and pushes 32..63.

Source files
------------

// File: rtl/rename_recovery_controller_pkg.sv
// Shared sizes, FSM state encoding and commit-lane record for rename recovery.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package processor_help;

    localparam int SUPER_SCALAR_WIDTH           = 2;
    localparam int ARCHITECTURAL_REGISTER_COUNT = 32;
    localparam int PHYSICAL_REGISTER_FILE_SIZE  = 64;

    localparam int AW = $clog2(ARCHITECTURAL_REGISTER_COUNT);
    localparam int PW = $clog2(PHYSICAL_REGISTER_FILE_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RESTORE,
        REBUILD,
        DONE
    } RecoveryState;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] arch_dest;
        logic [PW-1:0] phys_dest;
    } CommitLane;

endpackage

// File: rtl/rename_recovery_controller_if.sv
// Bundles the commit/retire lanes and the flush-recovery ports toward rename.
// Latency: wires only.
// Backpressure: busy_out is the stall the front end must honour during recovery.
interface rename_recovery_controller_if;
    import processor_help::*;

    localparam int W = SUPER_SCALAR_WIDTH;

    logic [W-1:0]          commit_valid_in;
    logic [W-1:0][AW-1:0]  commit_arch_dest_in;
    logic [W-1:0][PW-1:0]  commit_phys_dest_in;
    logic [W-1:0]          retire_valid_out;
    logic [W-1:0][PW-1:0]  retire_freed_register_out;
    logic                  flush_in;
    logic                  busy_out;
    logic                  freelist_clear_out;
    logic                  rat_restore_valid_out;
    logic [AW-1:0]         rat_restore_index_out;
    logic [PW-1:0]         rat_restore_value_out;
    logic                  freelist_push_valid_out;
    logic [PW-1:0]         freelist_push_register_out;
    logic                  recovery_done_out;

    // Commit/flush source (retire stage, testbench).
    modport master (
        output commit_valid_in, commit_arch_dest_in, commit_phys_dest_in, flush_in,
        input  retire_valid_out, retire_freed_register_out, busy_out,
               freelist_clear_out, rat_restore_valid_out, rat_restore_index_out,
               rat_restore_value_out, freelist_push_valid_out,
               freelist_push_register_out, recovery_done_out
    );

    // The recovery controller itself.
    modport slave (
        input  commit_valid_in, commit_arch_dest_in, commit_phys_dest_in, flush_in,
        output retire_valid_out, retire_freed_register_out, busy_out,
               freelist_clear_out, rat_restore_valid_out, rat_restore_index_out,
               rat_restore_value_out, freelist_push_valid_out,
               freelist_push_register_out, recovery_done_out
    );

endinterface

// File: rtl/rename_recovery_controller.sv
// Committed RAT keeper: frees retired mappings and sequences flush recovery of rename.
// Latency: retire outputs 1 cycle after commit; recovery takes 1 + A + P + 1 cycles.
// Backpressure: busy_out stalls decode/rename; commits while busy are dropped.
module rename_recovery_controller
    import processor_help::*;
(
    input  logic                          clk_in,
    input  logic                          rst_in,
    rename_recovery_controller_if.slave   rrc
);

    localparam int W = SUPER_SCALAR_WIDTH;
    localparam int A = ARCHITECTURAL_REGISTER_COUNT;
    localparam int P = PHYSICAL_REGISTER_FILE_SIZE;

    RecoveryState state_q, state_d;
    logic [PW-1:0] scan_q, scan_d;

    logic [PW-1:0] rat_q [A];
    logic [PW-1:0] rat_d [A];
    logic [P-1:0]  used_q, used_d;

    CommitLane lane [W];

    logic [W-1:0]         retire_valid_q, retire_valid_d;
    logic [W-1:0][PW-1:0] freed_q, freed_d;

    logic          busy_q;
    logic          clear_q;
    logic          restore_valid_q;
    logic [AW-1:0] restore_index_q;
    logic [PW-1:0] restore_value_q;
    logic          push_valid_q;
    logic [PW-1:0] push_reg_q;
    logic          done_q;

    // Gather the per-lane commit fields into lane records.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            lane[i].valid     = rrc.commit_valid_in[i];
            lane[i].arch_dest = rrc.commit_arch_dest_in[i];
            lane[i].phys_dest = rrc.commit_phys_dest_in[i];
        end
    end

    // Apply commits lane by lane so a higher lane sees the lower lane's new mapping.
    always_comb begin
        rat_d          = rat_q;
        used_d         = used_q;
        retire_valid_d = '0;
        freed_d        = '0;
        if (state_q == IDLE) begin
            for (int i = 0; i < W; i++) begin
                if (lane[i].valid) begin
                    retire_valid_d[i]          = 1'b1;
                    freed_d[i]                 = rat_d[lane[i].arch_dest];
                    used_d[rat_d[lane[i].arch_dest]] = 1'b0;
                    used_d[lane[i].phys_dest]  = 1'b1;
                    rat_d[lane[i].arch_dest]   = lane[i].phys_dest;
                end
            end
        end
    end

    // Committed map and occupancy bits; reset to the identity mapping.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < A; i++) begin
                rat_q[i] <= PW'(i);
            end
            used_q         <= {{(P-A){1'b0}}, {A{1'b1}}};
            retire_valid_q <= '0;
            freed_q        <= '0;
        end else begin
            rat_q          <= rat_d;
            used_q         <= used_d;
            retire_valid_q <= retire_valid_d;
            freed_q        <= freed_d;
        end
    end

    // Recovery sequencing; one scan counter serves both RESTORE and REBUILD.
    always_comb begin
        state_d = state_q;
        scan_d  = scan_q;
        case (state_q)
            IDLE: begin
                if (rrc.flush_in) begin
                    state_d = CLEAR;
                    scan_d  = '0;
                end
            end
            CLEAR: begin
                state_d = RESTORE;
                scan_d  = '0;
            end
            RESTORE: begin
                if (scan_q == PW'(A-1)) begin
                    state_d = REBUILD;
                    scan_d  = '0;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            REBUILD: begin
                if (scan_q == PW'(P-1)) begin
                    state_d = DONE;
                    scan_d  = '0;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                scan_d  = '0;
            end
            default: begin
                state_d = IDLE;
                scan_d  = '0;
            end
        endcase
    end

    // FSM state and scan counter registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            scan_q  <= '0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
        end
    end

    // Recovery outputs registered from the state being entered, one action per cycle.
    // The committed map is frozen outside IDLE, so rat_q is safe to read here.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q          <= 1'b0;
            clear_q         <= 1'b0;
            restore_valid_q <= 1'b0;
            restore_index_q <= '0;
            restore_value_q <= '0;
            push_valid_q    <= 1'b0;
            push_reg_q      <= '0;
            done_q          <= 1'b0;
        end else begin
            busy_q          <= (state_d != IDLE);
            clear_q         <= (state_d == CLEAR);
            restore_valid_q <= (state_d == RESTORE);
            restore_index_q <= (state_d == RESTORE) ? scan_d[AW-1:0] : '0;
            restore_value_q <= (state_d == RESTORE) ? rat_q[scan_d[AW-1:0]] : '0;
            push_valid_q    <= (state_d == REBUILD) && !used_q[scan_d];
            push_reg_q      <= ((state_d == REBUILD) && !used_q[scan_d]) ? scan_d : '0;
            done_q          <= (state_d == DONE);
        end
    end

    assign rrc.retire_valid_out           = retire_valid_q;
    assign rrc.retire_freed_register_out  = freed_q;
    assign rrc.busy_out                   = busy_q;
    assign rrc.freelist_clear_out         = clear_q;
    assign rrc.rat_restore_valid_out      = restore_valid_q;
    assign rrc.rat_restore_index_out      = restore_index_q;
    assign rrc.rat_restore_value_out      = restore_value_q;
    assign rrc.freelist_push_valid_out    = push_valid_q;
    assign rrc.freelist_push_register_out = push_reg_q;
    assign rrc.recovery_done_out          = done_q;

endmodule
